// File: rtl/conv_out_packer_pkg.sv
// Shared types and constants for the accumulator output packer.
package conv_out_packer_pkg;

    localparam int TOUT_DEF     = 4;
    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 32;
    localparam int DEPTH_DEF    = 8;
    localparam int LOG2_DEP_DEF = 3;

    localparam logic [2:0] WCODE_8B = 3'b111;
    localparam logic [2:0] WCODE_4B = 3'b011;
    localparam logic [2:0] WCODE_2B = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // log2 of the lane width in bits; unknown codes fall back to 1-bit lanes
    function automatic logic [1:0] width_shift(input logic [2:0] code);
        logic [1:0] sh;
        case (code)
            WCODE_8B: sh = 2'd3;
            WCODE_4B: sh = 2'd2;
            WCODE_2B: sh = 2'd1;
            default:  sh = 2'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/conv_out_packer_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop happens the same cycle.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEP   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG2_DEP-1:0]   wr_ptr_q;
    logic [LOG2_DEP-1:0]   rd_ptr_q;
    logic [LOG2_DEP:0]     count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count_q == (LOG2_DEP+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; its contents only matter behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/conv_out_packer.sv
// Packs TOUT-lane result beats of a selectable width into memory words with row-strided addresses.
//   state    | meaning
//   ST_IDLE  | waiting for start; beats here flag err[1]
//   ST_RUN   | packing beats, flushing words into the FIFO
//   ST_DRAIN | last row flushed, waiting for the FIFO to empty
//   ST_DONE  | one-cycle done pulse
module conv_out_packer
    import conv_out_packer_pkg::*;
#(
    parameter int TOUT     = TOUT_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LOG2_DEP = LOG2_DEP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           out_data_width,
    input  logic [AW-1:0]        cfg_base_addr,
    input  logic [AW-1:0]        cfg_row_stride,
    input  logic [15:0]          cfg_beats_row,
    input  logic [15:0]          cfg_rows,
    input  logic                 in_vld,
    input  logic [TOUT*DW-1:0]   in_dat,
    output logic                 wr_vld,
    input  logic                 wr_rdy,
    output logic [AW-1:0]        wr_addr,
    output logic [TOUT*DW-1:0]   wr_dat,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err
);

    localparam int WW   = TOUT * DW;
    localparam int BI_W = $clog2(DW);
    localparam int SH_W = $clog2(WW);

    state_t          state_q, state_d;
    logic [1:0]      wsh_q;
    logic [AW-1:0]   stride_q;
    logic [AW-1:0]   row_addr_q;
    logic [15:0]     beats_row_q;
    logic [15:0]     rows_q;
    logic [15:0]     beat_cnt_q;
    logic [15:0]     word_cnt_q;
    logic [15:0]     row_cnt_q;
    logic [BI_W-1:0] beat_idx_q;
    logic [WW-1:0]   pack_q;
    logic [1:0]      err_q;

    logic            beat_acc;
    logic            row_end;
    logic            last_row;
    logic            word_full;
    logic            flush;
    logic [BI_W-1:0] beat_last_idx;
    logic [SH_W-1:0] shamt;
    logic [WW-1:0]   lane_bits;
    logic [WW-1:0]   merged;
    logic [AW-1:0]   push_addr;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    assign beat_acc      = (state_q == ST_RUN) && in_vld;
    assign row_end       = (beat_cnt_q == beats_row_q - 16'd1);
    assign last_row      = (row_cnt_q == rows_q - 16'd1);
    assign beat_last_idx = BI_W'((DW >> wsh_q) - 1);
    assign word_full     = (beat_idx_q == beat_last_idx);
    assign flush         = beat_acc && (word_full || row_end);
    assign shamt         = SH_W'((int'(beat_idx_q) * TOUT) << wsh_q);
    assign merged        = pack_q | (lane_bits << shamt);
    assign push_addr     = row_addr_q + AW'(word_cnt_q);
    assign pop           = wr_vld && wr_rdy;
    assign wr_vld        = !fifo_empty;
    assign err           = err_q;

    // Compact each lane down to its low w bits, lane i landing at [i*w +: w].
    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < TOUT; i++) begin
            case (wsh_q)
                2'd3:    lane_bits[i*8 +: 8] = in_dat[i*DW +: 8];
                2'd2:    lane_bits[i*4 +: 4] = in_dat[i*DW +: 4];
                2'd1:    lane_bits[i*2 +: 2] = in_dat[i*DW +: 2];
                default: lane_bits[i]        = in_dat[i*DW];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (beat_acc && row_end && last_row) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsh_q       <= '0;
            stride_q    <= '0;
            row_addr_q  <= '0;
            beats_row_q <= '0;
            rows_q      <= '0;
            beat_cnt_q  <= '0;
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            beat_idx_q  <= '0;
            pack_q      <= '0;
            err_q       <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                wsh_q       <= width_shift(out_data_width);
                stride_q    <= cfg_row_stride;
                row_addr_q  <= cfg_base_addr;
                beats_row_q <= cfg_beats_row;
                rows_q      <= cfg_rows;
                beat_cnt_q  <= '0;
                word_cnt_q  <= '0;
                row_cnt_q   <= '0;
                beat_idx_q  <= '0;
                pack_q      <= '0;
                err_q       <= '0;
            end else begin
                if (in_vld && state_q != ST_RUN)      err_q[1] <= 1'b1;
                if (flush && fifo_full && !pop)       err_q[0] <= 1'b1;
            end

            // Counters advance even when the flushed word is dropped.
            if (beat_acc) begin
                if (row_end) begin
                    beat_cnt_q <= '0;
                    word_cnt_q <= '0;
                    row_cnt_q  <= row_cnt_q + 16'd1;
                    row_addr_q <= row_addr_q + stride_q;
                    beat_idx_q <= '0;
                    pack_q     <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 16'd1;
                    if (word_full) begin
                        word_cnt_q <= word_cnt_q + 16'd1;
                        beat_idx_q <= '0;
                        pack_q     <= '0;
                    end else begin
                        beat_idx_q <= beat_idx_q + 1'b1;
                        pack_q     <= merged;
                    end
                end
            end
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (AW + WW),
        .DEPTH      (DEPTH),
        .LOG2_DEP   (LOG2_DEP)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (flush),
        .push_data ({push_addr, merged}),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  ({wr_addr, wr_dat}),
        .empty     (fifo_empty)
    );

endmodule
